counter_8b: RTL and testbench

- 8-bit enable-gated up-counter with a registered terminal-count pulse.
- Counts qualified enable cycles from 0 up to a programmable terminal value, then wraps to 0.
- Emits a one-cycle done pulse on each wrap.
- Used as a small timing/event-count primitive: the enable is driven by an upstream strobe, and the done pulse feeds downstream control logic.

---
 rtl/counter_8b_if.sv | 22 ++
 rtl/counter_8b.sv | 49 ++++
 tb/tb_counter_8b.sv | 126 ++++++++++++
 3 files changed

// File: rtl/counter_8b_if.sv
// Count-enable / count-value bundle between an upstream strobe source and counter_8b.
interface counter_8b_if;
  localparam int unsigned CntW = 8;

  logic            i_en_cnt;
  logic [CntW-1:0] o_cnt;
  logic            o_cnt_done;

  // Strobe source drives the enable and observes the count.
  modport master (
    output i_en_cnt,
    input  o_cnt,
    input  o_cnt_done
  );

  // Counter receives the enable and drives the count.
  modport slave (
    input  i_en_cnt,
    output o_cnt,
    output o_cnt_done
  );
endinterface

// File: rtl/counter_8b.sv
// 8-bit enable-gated up-counter, 0..CNT_MAX then wrap, with a registered
// one-cycle done pulse on the edge that wraps the count back to zero.
module counter_8b #(
  parameter int unsigned CNT_MAX = 255
) (
  input  logic         clk,
  input  logic         rst_n,   // synchronous, active-high
  counter_8b_if.slave  bus
);
  localparam int unsigned CntW = 8;

  // Terminal value outside 1..255 would give a dead or unreachable wrap.
  if ((CNT_MAX < 1) || (CNT_MAX > 255)) begin : g_bad_cnt_max
    $fatal(1, "counter_8b: CNT_MAX=%0d outside legal range 1..255", CNT_MAX);
  end

  localparam logic [CntW-1:0] CntMaxV = CntW'(CNT_MAX);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Only an exact match with CNT_MAX wraps with done; a forced value above
  // CNT_MAX rolls through 255 to 0 silently via plain 8-bit overflow.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (bus.i_en_cnt) begin
      if (cnt_q == CntMaxV) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CntW'(1);
      end
    end
  end

  assign bus.o_cnt      = cnt_q;
  assign bus.o_cnt_done = done_q;
endmodule

// File: tb/tb_counter_8b.sv
// Directed bench for counter_8b: one instance at CNT_MAX=255, one at CNT_MAX=3.
module tb_counter_8b;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned pulses;

  counter_8b_if bus_a ();
  counter_8b_if bus_b ();

  counter_8b #(.CNT_MAX(255)) u_dut_a (.clk(clk), .rst_n(rst_a), .bus(bus_a.slave));
  counter_8b #(.CNT_MAX(3))   u_dut_b (.clk(clk), .rst_n(rst_b), .bus(bus_b.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned seq_b  [12] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
  int unsigned done_b [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
  logic        gate   [7]  = '{1, 0, 0, 1, 1, 0, 1};
  int unsigned gate_c [7]  = '{1, 1, 1, 2, 3, 3, 4};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.i_en_cnt = 1'b1;
    bus_b.i_en_cnt = 1'b0;

    // Reset held two edges with enable high.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_cnt", bus_a.o_cnt, 0);
      check("rst_done", bus_a.o_cnt_done, 0);
    end
    rst_a = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("post_rst_cnt", bus_a.o_cnt, i);
    end

    // Reset has no asynchronous effect between edges.
    #2 rst_a = 1'b1;
    #1 check("no_async_rst", bus_a.o_cnt, 3);
    tick();
    check("sync_rst_cnt", bus_a.o_cnt, 0);
    check("sync_rst_done", bus_a.o_cnt_done, 0);
    rst_a = 1'b0;

    // Full 256-edge period.
    pulses = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      check("full_cnt", bus_a.o_cnt, k % 256);
      check("full_done", bus_a.o_cnt_done, (k == 256) ? 1 : 0);
      if (bus_a.o_cnt_done) pulses++;
    end
    check("full_pulses", pulses, 1);
    tick();
    check("full_after_cnt", bus_a.o_cnt, 1);
    check("full_after_done", bus_a.o_cnt_done, 0);

    // Gated counting accumulates across dropped enables.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus_a.i_en_cnt = gate[i];
      tick();
      check("gate_cnt", bus_a.o_cnt, gate_c[i]);
      check("gate_done", bus_a.o_cnt_done, 0);
    end
    bus_a.i_en_cnt = 1'b0;

    // Short terminal, continuous enable.
    tick();
    rst_b = 1'b0;
    bus_b.i_en_cnt = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("short_cnt", bus_b.o_cnt, seq_b[i]);
      check("short_done", bus_b.o_cnt_done, done_b[i]);
    end

    // Reset on the wrap edge wins.
    for (int i = 0; i < 3; i++) tick();
    check("prio_pre_cnt", bus_b.o_cnt, 3);
    rst_b = 1'b1;
    tick();
    check("prio_cnt", bus_b.o_cnt, 0);
    check("prio_done", bus_b.o_cnt_done, 0);
    tick();
    check("prio_hold_done", bus_b.o_cnt_done, 0);
    rst_b = 1'b0;

    // Hold at terminal, then wrap.
    for (int i = 0; i < 3; i++) tick();
    check("hold_pre_cnt", bus_b.o_cnt, 3);
    bus_b.i_en_cnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_cnt", bus_b.o_cnt, 3);
      check("hold_done", bus_b.o_cnt_done, 0);
    end
    bus_b.i_en_cnt = 1'b1;
    tick();
    check("hold_wrap_cnt", bus_b.o_cnt, 0);
    check("hold_wrap_done", bus_b.o_cnt_done, 1);
    bus_b.i_en_cnt = 1'b0;
    tick();
    check("hold_idle_cnt", bus_b.o_cnt, 0);
    check("hold_idle_done", bus_b.o_cnt_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
